// File: rtl/mem_arbiter_if.sv
// Cache/memory bus bundle for mem_arbiter: icache and dcache request ports,
// halt handshake and the single shared RAM port.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imemREN;
    logic [ADDR_W-1:0] imemaddr;
    logic              ihit;
    logic [DATA_W-1:0] imemload;

    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;

    logic              halt;
    logic              halted;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ram_ready;

    // arbiter side
    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
               halt, ramload, ram_ready,
        output ihit, imemload, dhit, dmemload, halted,
               ramREN, ramWEN, ramaddr, ramstore
    );

    // cache / memory side
    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
               halt, ramload, ram_ready,
        input  ihit, imemload, dhit, dmemload, halted,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto a single variable-latency RAM port,
// data-first with bounded instruction starvation and a sticky halt.
//
// state  | meaning
// IDLE   | no access in flight; grant decision made here
// IACC   | instruction read outstanding on the RAM port
// DACC   | data read or write outstanding on the RAM port
// HALTED | closed to all requests until reset
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic          CLK,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_CAP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        HALTED
    } state_t;

    state_t            state;
    logic [SW-1:0]     streak;
    logic              halted_q;
    logic              ram_ren_q;
    logic              ram_wen_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_store_q;

    logic data_req;
    logic inst_turn;

    assign data_req  = bus.dmemREN | bus.dmemWEN;
    // instruction overrides data only once the streak has saturated, and never under halt
    assign inst_turn = bus.imemREN & ~bus.halt & (streak == STREAK_CAP);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= '0;
            halted_q    <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req && !inst_turn) begin
                        state       <= DACC;
                        ram_wen_q   <= bus.dmemWEN;
                        ram_ren_q   <= ~bus.dmemWEN;
                        ram_addr_q  <= bus.dmemaddr;
                        ram_store_q <= bus.dmemstore;
                        if (!bus.imemREN)
                            streak <= '0;
                        else if (streak != STREAK_CAP)
                            streak <= streak + SW'(1);
                    end else if (bus.imemREN && !bus.halt) begin
                        state      <= IACC;
                        ram_ren_q  <= 1'b1;
                        ram_addr_q <= bus.imemaddr;
                        streak     <= '0;
                    end else if (bus.halt) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                IACC, DACC: begin
                    if (bus.ram_ready) begin
                        state     <= IDLE;
                        ram_ren_q <= 1'b0;
                        ram_wen_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // hits complete in the ram_ready cycle so the cache can drop its request before the next IDLE
    assign bus.ihit     = ~rst & (state == IACC) & bus.ram_ready;
    assign bus.dhit     = ~rst & (state == DACC) & bus.ram_ready;
    assign bus.imemload = bus.ihit ? bus.ramload : '0;
    assign bus.dmemload = (bus.dhit && !ram_wen_q) ? bus.ramload : '0;

    assign bus.halted   = halted_q;
    assign bus.ramREN   = ram_ren_q;
    assign bus.ramWEN   = ram_wen_q;
    assign bus.ramaddr  = ram_addr_q;
    assign bus.ramstore = ram_store_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: inputs driven and outputs checked
// just after the falling edge, expected values written by hand.
module tb_mem_arbiter;
    logic CLK;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic quiet();
        bus.imemREN   = 0;
        bus.dmemREN   = 0;
        bus.dmemWEN   = 0;
        bus.halt      = 0;
        bus.ram_ready = 0;
        bus.ramload   = '0;
    endtask

    int hits[$];
    int nhits;
    int clash;

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1;
        quiet();
        bus.imemaddr  = '0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        @(negedge CLK);
        step();
        #1;
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_ihit", bus.ihit, 0);
        chk("rst_dhit", bus.dhit, 0);
        chk("rst_halted", bus.halted, 0);
        step();
        rst = 0;

        // single instruction read, ready two cycles after grant
        bus.imemREN = 1; bus.imemaddr = 32'h100;
        #1 chk("i_grant_cycle_ren", bus.ramREN, 0);
        step();
        bus.imemaddr = 32'h999;
        #1 chk("i_ren1", bus.ramREN, 1);
        chk("i_addr", bus.ramaddr, 32'h100);
        chk("i_nohit", bus.ihit, 0);
        step();
        bus.ram_ready = 1; bus.ramload = 32'hCAFE0001;
        #1 chk("i_ren2", bus.ramREN, 1);
        chk("i_addr_latched", bus.ramaddr, 32'h100);
        chk("i_hit", bus.ihit, 1);
        chk("i_load", bus.imemload, 32'hCAFE0001);
        chk("i_no_dhit", bus.dhit, 0);
        step();
        quiet();
        #1 chk("i_done_ren", bus.ramREN, 0);
        chk("i_done_hit", bus.ihit, 0);
        chk("i_done_load", bus.imemload, 0);

        // simultaneous instruction and data write: data first
        bus.imemREN = 1; bus.imemaddr = 32'h300;
        bus.dmemWEN = 1; bus.dmemaddr = 32'h200; bus.dmemstore = 32'hDEADBEEF;
        step();
        #1 chk("w_wen", bus.ramWEN, 1);
        chk("w_ren", bus.ramREN, 0);
        chk("w_addr", bus.ramaddr, 32'h200);
        chk("w_store", bus.ramstore, 32'hDEADBEEF);
        bus.ram_ready = 1; bus.ramload = 32'h5555AAAA;
        #1 chk("w_dhit", bus.dhit, 1);
        chk("w_ihit", bus.ihit, 0);
        chk("w_dload_zero", bus.dmemload, 0);
        step();
        bus.dmemWEN = 0; bus.ram_ready = 0;
        #1 chk("w_bubble_ren", bus.ramREN, 0);
        chk("w_bubble_wen", bus.ramWEN, 0);
        chk("w_bubble_dhit", bus.dhit, 0);
        step();
        #1 chk("wi_ren", bus.ramREN, 1);
        chk("wi_addr", bus.ramaddr, 32'h300);
        bus.ram_ready = 1; bus.ramload = 32'h12345678;
        #1 chk("wi_ihit", bus.ihit, 1);
        chk("wi_load", bus.imemload, 32'h12345678);
        step();
        quiet();

        // read+write together is a write
        bus.dmemREN = 1; bus.dmemWEN = 1; bus.dmemaddr = 32'h240; bus.dmemstore = 32'h0BADF00D;
        step();
        #1 chk("rw_wen", bus.ramWEN, 1);
        chk("rw_ren", bus.ramREN, 0);
        chk("rw_store", bus.ramstore, 32'h0BADF00D);
        bus.ram_ready = 1; bus.ramload = 32'h77;
        #1 chk("rw_dhit", bus.dhit, 1);
        chk("rw_dload", bus.dmemload, 0);
        step();
        quiet();

        // starvation bound: 4 data hits, then the instruction, then data resumes
        bus.dmemREN = 1; bus.dmemaddr = 32'h400;
        bus.imemREN = 1; bus.imemaddr = 32'h500;
        nhits = 0;
        clash = 0;
        for (int cyc = 0; cyc < 40 && nhits < 6; cyc++) begin
            bus.ram_ready = bus.ramREN | bus.ramWEN;
            bus.ramload   = 32'hA000 + cyc;
            #1;
            if ((bus.ramREN && bus.ramWEN) || (bus.ihit && bus.dhit)) clash++;
            if (bus.dhit) begin hits.push_back(1); nhits++; end
            if (bus.ihit) begin hits.push_back(2); nhits++; end
            step();
            if (hits.size() > 0 && hits[hits.size()-1] == 2) bus.imemREN = 0;
        end
        chk("starve_budget", nhits, 6);
        chk("starve_clash", clash, 0);
        for (int k = 0; k < 6; k++)
            chk($sformatf("starve_seq%0d", k), (k < hits.size()) ? hits[k] : 0,
                (k == 4) ? 2 : 1);
        quiet();
        step();

        // halt raised mid-instruction with a data read pending
        bus.imemREN = 1; bus.imemaddr = 32'h600;
        step();
        bus.halt = 1; bus.dmemREN = 1; bus.dmemaddr = 32'h700;
        step();
        bus.ram_ready = 1; bus.ramload = 32'h11;
        #1 chk("h_ihit", bus.ihit, 1);
        chk("h_iload", bus.imemload, 32'h11);
        chk("h_addr", bus.ramaddr, 32'h600);
        step();
        bus.imemREN = 0; bus.ram_ready = 0;
        #1 chk("h_not_yet", bus.halted, 0);
        step();
        #1 chk("h_d_ren", bus.ramREN, 1);
        chk("h_d_addr", bus.ramaddr, 32'h700);
        bus.ram_ready = 1; bus.ramload = 32'h22;
        #1 chk("h_dhit", bus.dhit, 1);
        chk("h_dload", bus.dmemload, 32'h22);
        step();
        bus.dmemREN = 0; bus.ram_ready = 0;
        #1 chk("h_idle_halted", bus.halted, 0);
        step();
        #1 chk("h_halted", bus.halted, 1);
        bus.halt = 0; bus.imemREN = 1; bus.dmemWEN = 1; bus.ram_ready = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            #1 chk($sformatf("h_strobe%0d", k), {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, 0);
            chk($sformatf("h_sticky%0d", k), bus.halted, 1);
        end

        // reset mid data access
        rst = 1; quiet();
        step();
        rst = 0;
        #1 chk("r_unhalt", bus.halted, 0);
        bus.dmemREN = 1; bus.dmemaddr = 32'h800;
        step();
        #1 chk("r_d_ren", bus.ramREN, 1);
        rst = 1; bus.ram_ready = 1; bus.ramload = 32'h33;
        #1 chk("r_no_dhit_rst", bus.dhit, 0);
        step();
        rst = 0; bus.dmemREN = 0;
        #1 chk("r_outs", {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, 0);
        chk("r_addr", bus.ramaddr, 0);
        chk("r_dload", bus.dmemload, 0);
        step();
        bus.ram_ready = 0; bus.imemREN = 1; bus.imemaddr = 32'h900;
        step();
        #1 chk("r_i_ren", bus.ramREN, 1);
        chk("r_i_addr", bus.ramaddr, 32'h900);
        bus.ram_ready = 1; bus.ramload = 32'h44;
        #1 chk("r_ihit", bus.ihit, 1);
        chk("r_iload", bus.imemload, 32'h44);
        step();
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive data grants while an instruction request is pending.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 imemREN  in  1  icache read request; held until ihit.
REQ-007 imemaddr  in  ADDR_W  icache read address.
REQ-008 ihit  out  1  one-cycle pulse; instruction read complete.
REQ-009 imemload  out  DATA_W  instruction data; valid only while ihit=1.
REQ-010 dmemREN  in  1  dcache read request; held until dhit.
REQ-011 dmemWEN  in  1  dcache write request; held until dhit.
REQ-012 dmemaddr  in  ADDR_W  dcache address.
REQ-013 dmemstore  in  DATA_W  dcache write data.
REQ-014 dhit  out  1  one-cycle pulse; data access complete.
REQ-015 dmemload  out  DATA_W  read data; valid only while dhit=1 for a read.
REQ-016 halt  in  1  datapath halt request.
REQ-017 halted  out  1  sticky; arbiter idle and closed to new requests.
REQ-018 ramREN  out  1  memory read strobe.
REQ-019 ramWEN  out  1  memory write strobe.
REQ-020 ramaddr  out  ADDR_W  memory address, registered at grant.
REQ-021 ramstore  out  DATA_W  memory write data, registered at grant.
REQ-022 ramload  in  DATA_W  memory read data, valid with ram_ready.
REQ-023 ram_ready  in  1  memory access complete this cycle; variable latency of at least 1 cycle.

Function
REQ-024 FSM states SHALL be IDLE, IACC, DACC and HALTED.
REQ-025 IDLE, halt=0: a pending data request SHALL be granted (DACC), except when streak=STARVE_MAX and imemREN=1, in which case the instruction SHALL be granted (IACC).
REQ-026 IDLE, only imemREN=1, halt=0: go IACC.
REQ-027 IDLE, no request: stay IDLE; ramREN=ramWEN=0.
REQ-028 On a grant, address (and store data for writes) SHALL be latched into ramaddr/ramstore; input changes during the access SHALL be ignored.
REQ-029 Grant decision is made in IDLE cycle N; ram strobe is asserted from cycle N+1 until the cycle ram_ready=1 inclusive.
REQ-030 IACC: ramREN=1; on ram_ready, ihit=1 and imemload=ramload that cycle, then go IDLE.
REQ-031 DACC: ramREN=1 for a read, or ramWEN=1 for a write; on ram_ready, dhit=1 (dmemload=ramload on a read), then go IDLE.
REQ-032 dmemREN=1 and dmemWEN=1 together SHALL be treated as a write.
REQ-033 ramREN and ramWEN SHALL never be 1 in the same cycle; ihit and dhit SHALL never be 1 in the same cycle.
REQ-034 Every access passes through IDLE, giving a one-cycle bubble; a request still held in the cycle after its hit SHALL be serviced as a new request.
REQ-035 streak counter, width clog2(STARVE_MAX+1): increments on a data grant while imemREN=1, saturating at STARVE_MAX; clears to 0 on an instruction grant or on a data grant with imemREN=0.
REQ-036 halt=1 in IDLE: imemREN SHALL be ignored; a pending data request SHALL still be granted; with no data request, go HALTED.
REQ-037 halt asserted during IACC or DACC: the access SHALL complete normally with its hit; halt is evaluated on return to IDLE.
REQ-038 HALTED: halted=1, all strobes 0, all requests ignored; only rst leaves HALTED; deassertion of halt has no effect.
REQ-039 ihit, dhit, imemload, dmemload SHALL be 0 whenever not validly driven.

Reset
REQ-040 rst=1 at an edge SHALL force IDLE, streak=0, halted=0, ramREN=ramWEN=0, ramaddr=ramstore=0, ihit=dhit=0, from the next cycle.
REQ-041 rst during IACC or DACC SHALL abandon the access with no hit pulse; a later ram_ready SHALL be ignored while in IDLE.

Verification
REQ-042 imemREN=1, imemaddr=0x100, ram_ready=1 two cycles after grant -> ramREN high 2 cycles with ramaddr=0x100; ihit pulses once with imemload=ramload.
REQ-043 imemREN=1 and dmemWEN=1 in the same IDLE cycle, dmemaddr=0x200, dmemstore=0xDEADBEEF -> data granted first (ramWEN=1, ramstore=0xDEADBEEF); after dhit, IDLE bubble, then instruction granted.
REQ-044 dmemREN held high continuously with imemREN=1, STARVE_MAX=4 -> exactly 4 dhit pulses, then 1 ihit, then data resumes.
REQ-045 halt=1 mid-IACC, dmemREN=1 pending -> ihit completes, data read serviced, next IDLE goes HALTED, halted=1; further requests produce no strobes.
REQ-046 rst pulse during DACC before ram_ready -> no dhit; all outputs 0 next cycle; a subsequent imemREN is serviced normally.
